// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO read-side drain block.
// State encoding, FSM state type and timer-width helpers.
package fifo_drain_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_POP  = 3'd1;
    localparam logic [ST_W-1:0] ST_SEND = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd3;
    localparam logic [ST_W-1:0] ST_GAP  = 3'd4;

    typedef enum logic [ST_W-1:0] {
        IDLE      = ST_IDLE,
        POP       = ST_POP,
        SEND      = ST_SEND,
        WAIT_DONE = ST_WAIT,
        GAP       = ST_GAP
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One extra bit so the terminal value never sits on the wrap point.
    function automatic int tmr_w(input int to_cycles, input int gap_cycles);
        return clog2(max3(to_cycles, gap_cycles, 1)) + 1;
    endfunction

endpackage

// File: rtl/fifo_tx_drain_if.sv
// FIFO read port plus transmitter handshake bundle.
// master = drain block, slave = FIFO/TX side.
interface fifo_tx_drain_if #(
    parameter int D_SIZE = 8
);
    logic              fifo_empty;
    logic [D_SIZE-1:0] fifo_data;
    logic              fifo_rd_inc;
    logic [D_SIZE-1:0] tx_data;
    logic              tx_valid;
    logic              tx_busy;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  tx_busy,
        output fifo_rd_inc,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output tx_busy,
        input  fifo_rd_inc,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/drain_timer.sv
// Shared up-counter for the SEND timeout and the inter-frame gap.
// Ports: clk, rstn (sync), clr, en, tc_val (terminal value), tc (cnt == tc_val).
module drain_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/fifo_tx_drain.sv
// Pops async-FIFO words one at a time and hands them to a serial TX.
// Ports: i_clk, i_rstn (sync low), i_enable, bus (FIFO + TX handshake),
//        o_sent_cnt, o_err_timeout (sticky), o_idle.
module fifo_tx_drain
    import fifo_drain_pkg::*;
#(
    parameter int D_SIZE     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TO_CYCLES  = 64,
    parameter int CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_enable,
    fifo_tx_drain_if.master    bus,
    output logic [CNT_W-1:0]   o_sent_cnt,
    output logic               o_err_timeout,
    output logic               o_idle
);
    localparam int TW = tmr_w(TO_CYCLES, GAP_CYCLES);

    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST =
        TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit NO_GAP = (GAP_CYCLES == 0);

    state_t            state;
    logic              valid_q;
    logic              err_q;
    logic              idle_q;
    logic [D_SIZE-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              go;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_hit;
    logic [TW-1:0]     tc_val;

    assign go = i_enable && !bus.fifo_empty;

    // Timer restarts from zero on every state change.
    always_comb begin
        tmr_clr = 1'b0;
        unique case (state)
            IDLE:      tmr_clr = go;
            POP:       tmr_clr = 1'b1;
            SEND:      tmr_clr = bus.tx_busy || tmr_hit;
            WAIT_DONE: tmr_clr = !bus.tx_busy;
            GAP:       tmr_clr = tmr_hit;
            default:   tmr_clr = 1'b1;
        endcase
    end

    assign tmr_en = (state == SEND) || (state == GAP);
    assign tc_val = (state == GAP) ? GAP_LAST : TO_LAST;

    drain_timer #(
        .W (TW)
    ) u_timer (
        .clk    (i_clk),
        .rstn   (i_rstn),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tc_val),
        .tc     (tmr_hit)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state  <= POP;
                        idle_q <= 1'b0;
                    end
                end
                POP: begin
                    state   <= SEND;
                    data_q  <= bus.fifo_data;
                    valid_q <= 1'b1;
                end
                SEND: begin
                    // Busy wins over a same-cycle timeout.
                    if (bus.tx_busy) begin
                        state   <= WAIT_DONE;
                        valid_q <= 1'b0;
                    end else if (tmr_hit) begin
                        err_q   <= 1'b1;
                        valid_q <= 1'b0;
                        if (NO_GAP) begin
                            state  <= IDLE;
                            idle_q <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (NO_GAP) begin
                            state  <= IDLE;
                            idle_q <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tmr_hit) begin
                        state  <= IDLE;
                        idle_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    // Only reachable from IDLE with a non-empty FIFO, so never pops empty.
    assign bus.fifo_rd_inc = (state == POP);
    assign bus.tx_data     = data_q;
    assign bus.tx_valid    = valid_q;
    assign o_sent_cnt      = cnt_q;
    assign o_err_timeout   = err_q;
    assign o_idle          = idle_q;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Directed bench for fifo_tx_drain: FIFO model, TX model, vector table.
// Covers reset, single word, table frames, burst, timeout, enable drop, reset.
module tb_fifo_tx_drain;

    localparam int GAP = 2;
    localparam int TO  = 64;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [15:0] cnt;
    logic        err;
    logic        idle;

    fifo_tx_drain_if #(.D_SIZE(8)) bus ();

    fifo_tx_drain #(
        .D_SIZE     (8),
        .GAP_CYCLES (GAP),
        .TO_CYCLES  (TO),
        .CNT_W      (16)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_enable      (en),
        .bus           (bus),
        .o_sent_cnt    (cnt),
        .o_err_timeout (err),
        .o_idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] tx_log[$];
    int         pop_cyc[$];
    int         fall_cyc[$];
    int         pops = 0;
    int         rd_empty_err = 0;

    bit tx_auto = 1'b1;
    int acc_dly = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    int vwait = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic upd();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        upd();
    endtask

    // FIFO read port: pop takes effect just after the edge that ends POP.
    always begin
        bit pend;
        @(negedge clk);
        pend = (bus.fifo_rd_inc === 1'b1);
        if (pend) begin
            if (q.size() == 0) rd_empty_err++;
            else begin
                pops++;
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (pend && q.size() > 0) q.delete(0);
        upd();
    end

    // TX: accepts after acc_dly extra valid cycles, busy for busy_len.
    always begin
        @(negedge clk);
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                bus.tx_busy = 1'b0;
                fall_cyc.push_back(cyc);
            end
        end else if (tx_auto && bus.tx_valid === 1'b1 && !bus.tx_busy) begin
            vwait++;
            if (vwait > acc_dly) begin
                bus.tx_busy = 1'b1;
                busy_cnt = busy_len;
                vwait = 0;
                tx_log.push_back(bus.tx_data);
            end
        end else begin
            vwait = 0;
        end
    end

    task automatic wait_valid(input string nm);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid_seen"}, 32'(bus.tx_valid), 1);
    endtask

    task automatic count_valid(output int n);
        n = 0;
        while (bus.tx_valid === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drained(input string nm, input int budget);
        int n = 0;
        while (!(q.size() == 0 && idle === 1'b1 && bus.tx_busy === 1'b0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, 32'(n < budget), 1);
    endtask

    function automatic logic [7:0] last_tx(input int back);
        if (tx_log.size() <= back) return 8'hxx;
        return tx_log[tx_log.size() - 1 - back];
    endfunction

    typedef struct {
        logic [7:0] data;
        int         acc;
        int         blen;
        int         exp_hi;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;

        vecs[0] = '{data: 8'h00, acc: 0, blen: 1,  exp_hi: 1, exp_cnt: 2};
        vecs[1] = '{data: 8'hFF, acc: 1, blen: 2,  exp_hi: 2, exp_cnt: 3};
        vecs[2] = '{data: 8'h3C, acc: 2, blen: 5,  exp_hi: 3, exp_cnt: 4};
        vecs[3] = '{data: 8'hC3, acc: 0, blen: 10, exp_hi: 1, exp_cnt: 5};

        rstn = 1'b0;
        en = 1'b1;
        bus.tx_busy = 1'b0;
        upd();
        push(8'hA5);

        // Reset held with a non-empty FIFO.
        repeat (3) @(negedge clk);
        chk("rst_rd_inc", 32'(bus.fifo_rd_inc), 0);
        chk("rst_valid", 32'(bus.tx_valid), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_data", 32'(bus.tx_data), 0);
        chk("rst_pops", pops, 0);

        // Single word: pop one cycle after release, valid the next.
        rstn = 1'b1;
        @(negedge clk);
        chk("t2_rd_inc", 32'(bus.fifo_rd_inc), 1);
        chk("t2_idle_low", 32'(idle), 0);
        @(negedge clk);
        chk("t2_rd_inc_pulse", 32'(bus.fifo_rd_inc), 0);
        chk("t2_valid", 32'(bus.tx_valid), 1);
        chk("t2_data", 32'(bus.tx_data), 32'h A5);
        wait_drained("t2", 100);
        chk("t2_pops", pops, 1);
        chk("t2_tx_word", 32'(last_tx(0)), 32'hA5);
        chk("t2_cnt", 32'(cnt), 1);
        chk("t2_data_hold", 32'(bus.tx_data), 32'hA5);

        // Vector table: single frames with varied accept delay / busy length.
        for (int i = 0; i < 4; i++) begin
            acc_dly = vecs[i].acc;
            busy_len = vecs[i].blen;
            push(vecs[i].data);
            wait_valid($sformatf("vec%0d", i));
            count_valid(n);
            wait_drained($sformatf("vec%0d", i), 100);
            chk($sformatf("vec%0d_valid_hi", i), n, vecs[i].exp_hi);
            chk($sformatf("vec%0d_tx", i), 32'(last_tx(0)), 32'(vecs[i].data));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_data", i), 32'(bus.tx_data),
                32'(vecs[i].data));
        end

        // Burst of four: order, count, and busy-fall to next-pop spacing
        // (WAIT_DONE exit edge + GAP cycles + IDLE decision edge).
        pop_cyc.delete();
        fall_cyc.delete();
        acc_dly = 0;
        busy_len = 3;
        p0 = pops;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_drained("burst", 400);
        chk("burst_pops", pops - p0, 4);
        chk("burst_cnt", 32'(cnt), 9);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_word%0d", i), 32'(last_tx(3 - i)), i + 1);
        end
        chk("burst_q_sizes", 32'(pop_cyc.size() == 4 && fall_cyc.size() == 4), 1);
        if (pop_cyc.size() == 4 && fall_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("burst_gap%0d", i),
                    pop_cyc[i + 1] - fall_cyc[i], GAP + 2);
            end
        end

        // Timeout: TX never accepts.
        tx_auto = 1'b0;
        p0 = pops;
        push(8'h77);
        push(8'h88);
        wait_valid("to");
        count_valid(n);
        chk("to_valid_hi", n, TO);
        chk("to_err", 32'(err), 1);
        wait_drained("to", 400);
        chk("to_pops", pops - p0, 2);
        chk("to_err_sticky", 32'(err), 1);
        chk("to_cnt", 32'(cnt), 9);
        chk("to_data", 32'(bus.tx_data), 32'h88);

        // Enable dropped while the first of three frames is in WAIT_DONE.
        tx_auto = 1'b1;
        acc_dly = 0;
        busy_len = 8;
        p0 = pops;
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        n = 0;
        while (bus.tx_busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("en_busy_seen", 32'(bus.tx_busy), 1);
        @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        chk("en_cnt", 32'(cnt), 10);
        chk("en_pops", pops - p0, 1);
        chk("en_idle", 32'(idle), 1);
        chk("en_q_left", q.size(), 2);
        en = 1'b1;
        wait_drained("en", 200);
        chk("en_cnt_final", 32'(cnt), 12);
        chk("en_tx_b2", 32'(last_tx(1)), 32'hB2);
        chk("en_tx_b3", 32'(last_tx(0)), 32'hB3);

        // Reset while in SEND: popped word is lost, next word follows.
        tx_auto = 1'b0;
        p0 = pops;
        push(8'h11);
        push(8'h22);
        wait_valid("mr");
        repeat (3) @(negedge clk);
        chk("mr_valid_pre", 32'(bus.tx_valid), 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(bus.tx_valid), 0);
        chk("mr_cnt", 32'(cnt), 0);
        chk("mr_err", 32'(err), 0);
        chk("mr_idle", 32'(idle), 1);
        chk("mr_data", 32'(bus.tx_data), 0);
        rstn = 1'b1;
        tx_auto = 1'b1;
        wait_drained("mr", 200);
        chk("mr_tx_next", 32'(last_tx(0)), 32'h22);
        chk("mr_cnt_after", 32'(cnt), 1);
        chk("mr_pops", pops - p0, 2);

        chk("never_pop_empty", rd_empty_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
